// File: rtl/opb_regbank_ppc2simulink.sv
// OPB slave register bank. Software writes shadow words; live words go to user logic
// either on a commit write (atomic mode) or directly (non-atomic mode).
module opb_regbank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_ATOMIC     = 1,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_update
);

  localparam logic [31:0] SPAN   = C_HIGHADDR - C_BASEADDR;
  localparam logic [29:0] W_CTRL = 30'(C_NUM_REGS);
  localparam logic [29:0] W_STAT = 30'(C_NUM_REGS + 1);
  localparam int unused_family_len = $bits(C_FAMILY);

  // Handshake FSM: one ACK cycle per hit; select is not sampled while in ACK.
  // Valid/ready view: OPB_select is the request, Sl_xferAck is the one-cycle
  // completion; a request still asserted after ACK starts a new transfer.
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
  state_t state_q, state_d;

  // Plain vector assignment maps OPB bit 0 onto the MSB (user bit 31).
  logic [C_OPB_AWIDTH-1:0] abus;
  logic [C_OPB_DWIDTH-1:0] dbus;
  logic [3:0]              be;
  assign abus = OPB_ABus;
  assign dbus = OPB_DBus;
  assign be   = OPB_BE;

  logic [32:0] offset;
  logic        hit;
  assign offset = {1'b0, abus} - {1'b0, C_BASEADDR};
  assign hit    = OPB_select && !offset[32] && (offset[31:0] <= SPAN);

  logic                  unused_ok;
  assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0]};

  // Transfer captured on the hit edge, consumed at the end of the ACK cycle.
  logic [29:0] word_q;
  logic        rnw_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  logic [31:0]           shadow_q [C_NUM_REGS];
  logic [31:0]           live_q   [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] pending_q;
  logic [C_NUM_REGS-1:0] update_q;
  logic [15:0]           commit_count_q;

  logic [31:0] sel_shadow;
  logic [31:0] merged;
  logic [31:0] rd_data;
  logic [15:0] pend16;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_shadow = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (word_q == 30'(i)) sel_shadow = shadow_q[i];
    end
    merged = sel_shadow;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = data_q[8*b +: 8];
    end
    pend16 = '0;
    pend16[C_NUM_REGS-1:0] = pending_q;
    rd_data = '0;
    if (word_q < W_CTRL) rd_data = sel_shadow;
    else if (word_q == W_STAT) rd_data = {commit_count_q, pend16};
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q        <= IDLE;
      word_q         <= '0;
      rnw_q          <= 1'b0;
      data_q         <= '0;
      be_q           <= '0;
      pending_q      <= '0;
      update_q       <= '0;
      commit_count_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      update_q <= '0;
      if (state_q == IDLE && hit) begin
        word_q <= offset[31:2];
        rnw_q  <= OPB_RNW;
        data_q <= dbus;
        be_q   <= be;
      end
      if (state_q == ACK && !rnw_q) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (word_q == 30'(i)) begin
            shadow_q[i] <= merged;
            if (C_ATOMIC != 0) begin
              pending_q[i] <= 1'b1;
            end else begin
              live_q[i]   <= merged;
              update_q[i] <= 1'b1;
            end
          end
        end
        if (word_q == W_CTRL && data_q[0]) begin
          commit_count_q <= commit_count_q + 16'd1;
          if (C_ATOMIC != 0) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
              if (pending_q[i]) begin
                live_q[i]   <= shadow_q[i];
                update_q[i] <= 1'b1;
              end
            end
            pending_q <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = live_q[g];
  end

  assign user_update = update_q;
  assign Sl_xferAck  = (state_q == ACK);
  assign Sl_DBus     = (state_q == ACK && rnw_q) ? rd_data : 32'h0;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_regbank_ppc2simulink.sv
// Directed bench: one atomic and one non-atomic instance share the OPB inputs.
module tb_opb_regbank_ppc2simulink;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;

  logic [0:31]  dbus_a, dbus_b;
  logic         err_a, retry_a, tout_a, ack_a;
  logic         err_b, retry_b, tout_b, ack_b;
  logic [127:0] udata_a, udata_b;
  logic [3:0]   upd_a, upd_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  opb_regbank_ppc2simulink #(.C_ATOMIC(1)) dut_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(dbus_a), .Sl_errAck(err_a), .Sl_retry(retry_a), .Sl_toutSup(tout_a),
    .Sl_xferAck(ack_a), .user_data_out(udata_a), .user_update(upd_a)
  );

  opb_regbank_ppc2simulink #(.C_ATOMIC(0)) dut_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(dbus_b), .Sl_errAck(err_b), .Sl_retry(retry_b), .Sl_toutSup(tout_b),
    .Sl_xferAck(ack_b), .user_data_out(udata_b), .user_update(upd_b)
  );

  // Drives a one-cycle select; returns #1 after the hit edge (ACK cycle).
  task automatic start_xfer(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    abus = a; dbus = d; be = b; rnw = r; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; abus = 32'h0; dbus = 32'h0; be = 4'h0; rnw = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ack: got %b/%b want 0/0", ack_a, ack_b);
    end
    tests_run++;
    if (dbus_a !== 32'h0 || udata_a !== 128'h0 || upd_a !== 4'h0 || udata_b !== 128'h0) begin
      tests_failed++; $display("FAIL reset_state: dbus %h udata %h upd %b", dbus_a, udata_a, upd_a);
    end
    tests_run++;
    if (err_a !== 1'b0 || retry_a !== 1'b0 || tout_a !== 1'b0) begin
      tests_failed++; $display("FAIL tied_outputs: got %b%b%b want 000", err_a, retry_a, tout_a);
    end
  endtask

  task automatic test_atomic_write();
    start_xfer(1'b0, 32'h0, 32'hDEADBEEF, 4'b1111);
    tests_run++;
    if (ack_a !== 1'b1) begin
      tests_failed++; $display("FAIL write_ack: got %b want 1", ack_a);
    end
    next_cycle();
    tests_run++;
    if (udata_a[31:0] !== 32'h0 || upd_a !== 4'h0) begin
      tests_failed++; $display("FAIL atomic_hold: live %h upd %b want 0/0", udata_a[31:0], upd_a);
    end
    tests_run++;
    if (udata_b[31:0] !== 32'hDEADBEEF || upd_b !== 4'b0001) begin
      tests_failed++; $display("FAIL direct_w0: live %h upd %b want deadbeef/0001", udata_b[31:0], upd_b);
    end
    start_xfer(1'b1, 32'h0, 32'h0, 4'b1111);
    tests_run++;
    if (ack_a !== 1'b1 || dbus_a !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL read_w0: ack %b data %h want 1/deadbeef", ack_a, dbus_a);
    end
    next_cycle();
    start_xfer(1'b1, 32'h14, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h00000001) begin
      tests_failed++; $display("FAIL status_pending: got %h want 00000001", dbus_a);
    end
    next_cycle();
  endtask

  task automatic test_commit();
    start_xfer(1'b0, 32'h10, 32'h1, 4'b1111);
    next_cycle();
    tests_run++;
    if (udata_a[31:0] !== 32'hDEADBEEF || upd_a !== 4'b0001) begin
      tests_failed++; $display("FAIL commit_load: live %h upd %b want deadbeef/0001", udata_a[31:0], upd_a);
    end
    next_cycle();
    tests_run++;
    if (upd_a !== 4'h0) begin
      tests_failed++; $display("FAIL commit_pulse_width: upd %b want 0000", upd_a);
    end
    start_xfer(1'b1, 32'h14, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h00010000 || dbus_b !== 32'h00010000) begin
      tests_failed++; $display("FAIL status_commit: got %h/%h want 00010000", dbus_a, dbus_b);
    end
    next_cycle();
    start_xfer(1'b1, 32'h10, 32'h0, 4'b1111);
    tests_run++;
    if (ack_a !== 1'b1 || dbus_a !== 32'h0) begin
      tests_failed++; $display("FAIL ctrl_read: ack %b data %h want 1/0", ack_a, dbus_a);
    end
    next_cycle();
  endtask

  task automatic test_byte_enable();
    start_xfer(1'b0, 32'h4, 32'h11223344, 4'b0100);
    next_cycle();
    tests_run++;
    if (udata_b[63:32] !== 32'h00220000) begin
      tests_failed++; $display("FAIL be_direct: got %h want 00220000", udata_b[63:32]);
    end
    start_xfer(1'b1, 32'h4, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h00220000) begin
      tests_failed++; $display("FAIL be_shadow: got %h want 00220000", dbus_a);
    end
    next_cycle();
  endtask

  task automatic test_direct_latency();
    start_xfer(1'b0, 32'h8, 32'hCAFEF00D, 4'b1111);
    tests_run++;
    if (udata_b[95:64] !== 32'h0 || upd_b !== 4'h0) begin
      tests_failed++; $display("FAIL direct_early: live %h upd %b want 0/0", udata_b[95:64], upd_b);
    end
    next_cycle();
    tests_run++;
    if (udata_b[95:64] !== 32'hCAFEF00D || upd_b !== 4'b0100) begin
      tests_failed++; $display("FAIL direct_w2: live %h upd %b want cafef00d/0100", udata_b[95:64], upd_b);
    end
    next_cycle();
    tests_run++;
    if (upd_b !== 4'h0) begin
      tests_failed++; $display("FAIL direct_pulse_width: upd %b want 0000", upd_b);
    end
    start_xfer(1'b1, 32'h14, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h00010006 || dbus_b !== 32'h00010000) begin
      tests_failed++; $display("FAIL status_mixed: got %h/%h want 00010006/00010000", dbus_a, dbus_b);
    end
    next_cycle();
  endtask

  task automatic test_be_zero();
    start_xfer(1'b0, 32'hC, 32'hFFFFFFFF, 4'b0000);
    tests_run++;
    if (ack_a !== 1'b1) begin
      tests_failed++; $display("FAIL be0_ack: got %b want 1", ack_a);
    end
    next_cycle();
    start_xfer(1'b1, 32'hC, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h0 || dbus_b !== 32'h0) begin
      tests_failed++; $display("FAIL be0_data: got %h/%h want 0/0", dbus_a, dbus_b);
    end
    next_cycle();
    start_xfer(1'b1, 32'h14, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h0001000E) begin
      tests_failed++; $display("FAIL be0_pending: got %h want 0001000e", dbus_a);
    end
    next_cycle();
  endtask

  task automatic test_unmapped();
    int acks;
    start_xfer(1'b1, 32'h24, 32'h0, 4'b1111);
    tests_run++;
    if (ack_a !== 1'b1 || dbus_a !== 32'h0) begin
      tests_failed++; $display("FAIL unmapped_read: ack %b data %h want 1/0", ack_a, dbus_a);
    end
    next_cycle();
    acks = 0;
    abus = 32'h100; rnw = 1'b1; sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (ack_a || ack_b) acks++;
    end
    sel = 1'b0; abus = 32'h0;
    tests_run++;
    if (acks !== 0) begin
      tests_failed++; $display("FAIL no_hit_ack: got %0d acks want 0", acks);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    abus = 32'h0; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    next_cycle(); seen[3] = ack_a;
    next_cycle(); seen[2] = ack_a;
    next_cycle(); seen[1] = ack_a;
    sel = 1'b0;
    next_cycle(); seen[0] = ack_a;
    tests_run++;
    if (seen !== 4'b1010) begin
      tests_failed++; $display("FAIL back_to_back_ack: got %b want 1010", seen);
    end
  endtask

  task automatic test_reset_in_ack();
    start_xfer(1'b0, 32'h0, 32'h12345678, 4'b1111);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    tests_run++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      tests_failed++; $display("FAIL rst_ack_drop: got %b/%b want 0/0", ack_a, ack_b);
    end
    tests_run++;
    if (udata_a !== 128'h0 || udata_b !== 128'h0 || upd_a !== 4'h0 || upd_b !== 4'h0) begin
      tests_failed++; $display("FAIL rst_clear: udata %h/%h want 0", udata_a, udata_b);
    end
    start_xfer(1'b1, 32'h0, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h0 || dbus_b !== 32'h0) begin
      tests_failed++; $display("FAIL rst_shadow: got %h/%h want 0/0", dbus_a, dbus_b);
    end
    next_cycle();
    start_xfer(1'b1, 32'h14, 32'h0, 4'b1111);
    tests_run++;
    if (dbus_a !== 32'h0) begin
      tests_failed++; $display("FAIL rst_status: got %h want 0", dbus_a);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_atomic_write();
    test_commit();
    test_byte_enable();
    test_direct_latency();
    test_be_zero();
    test_unmapped();
    test_back_to_back();
    test_reset_in_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/opb_regbank_ppc2simulink.md
OPB_REGBANK_PPC2SIMULINK -- requirements
Module: opb_regbank_ppc2simulink

Interface
REQ-001 Parameters SHALL be exactly:
- C_BASEADDR, 32'h00000000, first byte address of the register window
- C_HIGHADDR, 32'h000000FF, last byte address of the register window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_NUM_REGS, 4, number of software-writable words (1..16)
- C_ATOMIC, 1, 1 = writes held until commit; 0 = writes apply directly
- C_FAMILY, "virtex5", target family, no functional effect

REQ-002 Ports SHALL be exactly:
- OPB_Clk  in  1  sole clock; the user logic runs on this clock
- OPB_Rst  in  1  reset, synchronous, active-high
- OPB_ABus  in  [0:31]  transfer address
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer in progress
- OPB_seqAddr  in  1  sequential hint; ignored
- Sl_DBus  out  [0:31]  read data; all zero except in the ack cycle
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- user_data_out  out  [32*C_NUM_REGS-1:0]  live register values; word i in bits [32i+31:32i]
- user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse when live word i is loaded

Function
REQ-003 A hit SHALL be defined as OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index w = (OPB_ABus - C_BASEADDR) >> 2.
REQ-004 The address map SHALL be:
- w < C_NUM_REGS: shadow word w, R/W
- w = C_NUM_REGS: control word; writing 1 to bit 0 commits; reads return 0
- w = C_NUM_REGS+1: status word, read-only = {commit_count[15:0], pending[15:0]}, where pending is zero-extended
- any other w: reads return 0 and writes are ignored; the transfer is still acked
REQ-005 The handshake FSM SHALL have two states, IDLE and ACK. IDLE -> ACK on a hit; ACK -> IDLE unconditionally. Sl_xferAck = 1 exactly while in ACK.
REQ-006 Latency SHALL be as follows: with a hit sampled at edge k, Sl_xferAck is high in cycle k+1. The write takes effect at edge k+2. Sl_DBus carries read data during cycle k+1.
REQ-007 In ACK, the FSM SHALL not sample OPB_select. A select still high in the first IDLE cycle after ACK is treated as a new transfer.
REQ-008 Bit mapping: OPB bit 0 SHALL map to user bit 31. A write SHALL update only the bytes whose OPB_BE bit is 1.
REQ-009 With C_ATOMIC=1, a write to shadow word w SHALL set pending[w]. On a commit write, every word with pending=1 SHALL be copied to user_data_out, its user_update bit SHALL pulse in the following cycle, pending SHALL clear, and commit_count SHALL increment.
REQ-010 A commit with pending=0 SHALL still increment commit_count and SHALL pulse no update.
REQ-011 With C_ATOMIC=0, a write to word w SHALL load both shadow and live word w at the same edge, and user_update[w] SHALL pulse in the next cycle. pending SHALL stay 0, and a commit write SHALL only increment commit_count.
REQ-012 commit_count SHALL wrap from 16'hFFFF to 0.
REQ-013 A read of a shadow word SHALL return the shadow value, not the live value.
REQ-014 A write with OPB_BE=0000 SHALL be acked and change no data. In atomic mode it SHALL still set pending[w].

Reset
REQ-015 While OPB_Rst=1 at a rising edge:
- the FSM goes to IDLE
- shadow words, live words, pending and commit_count are cleared to 0
- Sl_xferAck, Sl_DBus and user_update are driven 0
- an in-flight transfer is dropped without ack

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- C_ATOMIC=1: write 32'hDEADBEEF to w=0, then read w=0 and the status word -> read data DEADBEEF, user_data_out word0 still 0, status 32'h00000001
- Commit after the first scenario -> word0 = DEADBEEF, user_update[0] pulses once for 1 cycle, status 32'h00010000
- Write 32'h11223344 with BE=0100 to a word holding 0 -> word = 32'h00220000
- C_ATOMIC=0: write w=2 -> live word2 changes at edge k+2, user_update[2] pulses in cycle k+2
- Read w=C_NUM_REGS+5 -> ack in cycle k+1 with Sl_DBus=0; no address hit -> no ack ever
- Assert reset in the ACK cycle of a write -> no write, Sl_xferAck low the next cycle, all state 0
